// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths and port-2 owner encoding for the memory port arbiter.
package mem_arb_pkg;
    localparam int DEF_ADDR_W = 16;
    localparam int DEF_DATA_W = 16;
    localparam int BURST_W = 4;
    typedef enum logic {
        OWN_D = 1'b0,
        OWN_M = 1'b1
    } owner_e;
endpackage

// File: rtl/rr_burst_arb2.sv
// rr_burst_arb2: two-requester round-robin arbiter with bounded locked bursts for M; gnt[0]=D, gnt[1]=M.
module rr_burst_arb2
    import mem_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       d_req,
    input  logic       m_req,
    input  logic       m_lock,
    output logic [1:0] gnt
);
    localparam logic [BURST_W-1:0] MAX_B = BURST_W'(MAX_BURST);
    owner_e ptr_q, ptr_d, own;
    logic [BURST_W-1:0] cnt_q, cnt_d;
    logic req_d, req_m, hit, keep_m;
    always_comb begin
        req_d = d_req & ~reset;
        req_m = m_req & ~reset;
        own = (req_d && req_m) ? ptr_q : (req_m ? OWN_M : OWN_D);
        gnt = {req_m & (own == OWN_M), req_d & (own == OWN_D)};
        // the locked grant that fills the burst hands the next cycle to a waiting D
        hit = cnt_q >= MAX_B - BURST_W'(1);
        keep_m = gnt[1] && m_lock && !(hit && req_d);
        ptr_d = gnt[0] ? OWN_M : (gnt[1] ? (keep_m ? OWN_M : OWN_D) : ptr_q);
        cnt_d = keep_m ? (hit ? MAX_B : cnt_q + BURST_W'(1)) : ((|gnt) ? '0 : cnt_q);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= OWN_D;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: sequences CPU fetch (port 1) and shared CPU-data/DMA (port 2) accesses to a two-port memory.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    input  logic              m_req,
    input  logic              m_we,
    input  logic              m_lock,
    input  logic [ADDR_W-1:0] m_addr,
    input  logic [DATA_W-1:0] m_wdata,
    output logic              m_gnt,
    output logic              m_rvalid,
    output logic [DATA_W-1:0] m_rdata,
    output logic [ADDR_W-1:0] mem_A1,
    output logic [DATA_W-1:0] mem_W1,
    output logic              mem_Write1,
    output logic              mem_Read1,
    input  logic [DATA_W-1:0] mem_R1,
    output logic [ADDR_W-1:0] mem_A2,
    output logic [DATA_W-1:0] mem_W2,
    output logic              mem_Write2,
    output logic              mem_Read2,
    input  logic [DATA_W-1:0] mem_R2
);
    logic [1:0] gnt;
    logic if_rvalid_q, if_rvalid_d, d_rvalid_q, d_rvalid_d, m_rvalid_q, m_rvalid_d;
    rr_burst_arb2 #(.MAX_BURST(MAX_BURST)) u_arb (
        .clk   (clk),
        .reset (reset),
        .d_req (d_req),
        .m_req (m_req),
        .m_lock(m_lock),
        .gnt   (gnt)
    );
    always_comb begin
        if_gnt = if_req & ~reset;
        d_gnt = gnt[0];
        m_gnt = gnt[1];
        mem_A1 = if_addr;
        mem_W1 = '0;
        mem_Write1 = 1'b0;
        mem_Read1 = if_gnt;
        mem_A2 = m_gnt ? m_addr : d_addr;
        mem_W2 = m_gnt ? m_wdata : d_wdata;
        mem_Write2 = (d_gnt & d_we) | (m_gnt & m_we);
        mem_Read2 = (d_gnt & ~d_we) | (m_gnt & ~m_we);
        if_rvalid_d = if_gnt;
        d_rvalid_d = d_gnt & ~d_we;
        m_rvalid_d = m_gnt & ~m_we;
        if_rvalid = if_rvalid_q;
        d_rvalid = d_rvalid_q;
        m_rvalid = m_rvalid_q;
        if_rdata = mem_R1;
        d_rdata = mem_R2;
        m_rdata = mem_R2;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            m_rvalid_q <= 1'b0;
        end else begin
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            m_rvalid_q <= m_rvalid_d;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenario bench for mem_port_arbiter with a 1k x 16 two-port memory model.
module tb_mem_port_arbiter;
    logic clk = 1'b0, reset = 1'b1;
    logic if_req = 0, d_req = 0, d_we = 0, m_req = 0, m_we = 0, m_lock = 0;
    logic [15:0] if_addr = 0, d_addr = 0, d_wdata = 0, m_addr = 0, m_wdata = 0;
    logic if_gnt, if_rvalid, d_gnt, d_rvalid, m_gnt, m_rvalid;
    logic [15:0] if_rdata, d_rdata, m_rdata;
    logic [15:0] mem_A1, mem_W1, mem_A2, mem_W2;
    logic mem_Write1, mem_Read1, mem_Write2, mem_Read2;
    logic [15:0] mem_R1 = 0, mem_R2 = 0;
    logic [15:0] mem [0:1023];
    logic ld_en = 0;
    logic [9:0] ld_addr = 0;
    logic [15:0] ld_data = 0;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (mem_Read1) mem_R1 <= mem[mem_A1[9:0]];
        if (mem_Read2) mem_R2 <= mem[mem_A2[9:0]];
        if (mem_Write2) mem[mem_A2[9:0]] <= mem_W2;
    end

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .m_req(m_req), .m_we(m_we), .m_lock(m_lock), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .mem_A1(mem_A1), .mem_W1(mem_W1), .mem_Write1(mem_Write1), .mem_Read1(mem_Read1), .mem_R1(mem_R1),
        .mem_A2(mem_A2), .mem_W2(mem_W2), .mem_Write2(mem_Write2), .mem_Read2(mem_Read2), .mem_R2(mem_R2)
    );

    task automatic preload(input logic [9:0] a, input logic [15:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        @(posedge clk); #1;
        ld_en = 0;
        @(negedge clk);
    endtask

    task automatic idle();
        if_req = 0; d_req = 0; m_req = 0; d_we = 0; m_we = 0; m_lock = 0;
    endtask

    task automatic apply_reset();
        idle();
        reset = 1;
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_reset();
        if_req = 1; d_req = 1; m_req = 1; m_lock = 1;
        #1;
        checks++;
        if ({if_gnt, d_gnt, m_gnt} !== 3'b000) begin
            failures++; $display("FAIL reset_gnt got=%b exp=000", {if_gnt, d_gnt, m_gnt});
        end
        checks++;
        if ({mem_Read1, mem_Write1, mem_Read2, mem_Write2} !== 4'b0000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0000", {mem_Read1, mem_Write1, mem_Read2, mem_Write2});
        end
        @(posedge clk); #1;
        checks++;
        if ({if_rvalid, d_rvalid, m_rvalid} !== 3'b000) begin
            failures++; $display("FAIL reset_rvalid got=%b exp=000", {if_rvalid, d_rvalid, m_rvalid});
        end
        checks++;
        if (mem_W1 !== 16'h0) begin
            failures++; $display("FAIL reset_w1 got=%h exp=0000", mem_W1);
        end
        idle();
        @(negedge clk);
        reset = 0;
    endtask

    task automatic test_fetch();
        preload(10'h010, 16'hBEEF);
        if_req = 1; if_addr = 16'h0010;
        #1;
        checks++;
        if ({if_gnt, mem_Read1, mem_Write1} !== 3'b110 || mem_A1 !== 16'h0010) begin
            failures++; $display("FAIL fetch_gnt got=%b/%h exp=110/0010", {if_gnt, mem_Read1, mem_Write1}, mem_A1);
        end
        checks++;
        if (if_rvalid !== 1'b0) begin
            failures++; $display("FAIL fetch_early_rvalid got=%b exp=0", if_rvalid);
        end
        @(posedge clk); #1;
        if_req = 0;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'hBEEF) begin
            failures++; $display("FAIL fetch_data got=%b/%h exp=1/beef", if_rvalid, if_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            failures++; $display("FAIL fetch_rvalid_pulse got=%b exp=0", if_rvalid);
        end
        @(negedge clk);
    endtask

    task automatic test_alternate();
        logic [3:0] exp_d;
        preload(10'h030, 16'hD0D0);
        preload(10'h040, 16'hA0A0);
        apply_reset();
        exp_d = 4'b0101;
        d_req = 1; d_we = 0; d_addr = 16'h0030;
        m_req = 1; m_we = 0; m_lock = 0; m_addr = 16'h0040;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({d_gnt, m_gnt} !== {exp_d[i], ~exp_d[i]} || mem_A2 !== (exp_d[i] ? 16'h0030 : 16'h0040)) begin
                failures++; $display("FAIL alt_gnt[%0d] got=%b/%h exp=%b", i, {d_gnt, m_gnt}, mem_A2, {exp_d[i], ~exp_d[i]});
            end
            @(posedge clk); #1;
            checks++;
            if ({d_rvalid, m_rvalid} !== {exp_d[i], ~exp_d[i]} || d_rdata !== (exp_d[i] ? 16'hD0D0 : 16'hA0A0)) begin
                failures++; $display("FAIL alt_rvalid[%0d] got=%b/%h exp=%b", i, {d_rvalid, m_rvalid}, d_rdata, {exp_d[i], ~exp_d[i]});
            end
            @(negedge clk);
        end
        idle();
        @(posedge clk); #1;
        checks++;
        if ({d_rvalid, m_rvalid} !== 2'b00) begin
            failures++; $display("FAIL alt_rvalid_idle got=%b exp=00", {d_rvalid, m_rvalid});
        end
        @(negedge clk);
    endtask

    task automatic test_burst();
        logic [6:0] exp_d;
        apply_reset();
        exp_d = 7'b0100001;
        d_req = 1; m_req = 1; m_lock = 1; d_we = 0; m_we = 0;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if ({d_gnt, m_gnt} !== {exp_d[i], ~exp_d[i]}) begin
                failures++; $display("FAIL burst_gnt[%0d] got=%b exp=%b", i, {d_gnt, m_gnt}, {exp_d[i], ~exp_d[i]});
            end
            @(negedge clk);
        end
        idle();
    endtask

    task automatic test_read_before_write();
        preload(10'h020, 16'h5555);
        d_req = 1; d_we = 1; d_addr = 16'h0020; d_wdata = 16'h1234;
        if_req = 1; if_addr = 16'h0020;
        #1;
        checks++;
        if ({d_gnt, if_gnt, mem_Write2, mem_Read2} !== 4'b1110 || mem_W2 !== 16'h1234) begin
            failures++; $display("FAIL rbw_drive got=%b/%h exp=1110/1234", {d_gnt, if_gnt, mem_Write2, mem_Read2}, mem_W2);
        end
        @(posedge clk); #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'h5555) begin
            failures++; $display("FAIL rbw_old got=%b/%h exp=1/5555", if_rvalid, if_rdata);
        end
        @(negedge clk);
        d_req = 0;
        @(posedge clk); #1;
        checks++;
        if (if_rvalid !== 1'b1 || if_rdata !== 16'h1234) begin
            failures++; $display("FAIL rbw_new got=%b/%h exp=1/1234", if_rvalid, if_rdata);
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_reset_inflight();
        m_req = 1; m_we = 0; m_lock = 1; m_addr = 16'h0040;
        #1;
        checks++;
        if ({d_gnt, m_gnt, mem_Read2} !== 3'b011) begin
            failures++; $display("FAIL inflight_gnt got=%b exp=011", {d_gnt, m_gnt, mem_Read2});
        end
        @(negedge clk);
        reset = 1; d_req = 1;
        #1;
        checks++;
        if ({if_gnt, d_gnt, m_gnt, mem_Read2, mem_Write2} !== 5'b00000) begin
            failures++; $display("FAIL inflight_reset_out got=%b exp=00000", {if_gnt, d_gnt, m_gnt, mem_Read2, mem_Write2});
        end
        @(posedge clk); #1;
        checks++;
        if (m_rvalid !== 1'b0) begin
            failures++; $display("FAIL inflight_rvalid got=%b exp=0", m_rvalid);
        end
        @(negedge clk);
        reset = 0;
        #1;
        checks++;
        if ({d_gnt, m_gnt} !== 2'b10) begin
            failures++; $display("FAIL post_reset_first got=%b exp=10", {d_gnt, m_gnt});
        end
        @(negedge clk);
        idle();
    endtask

    task automatic test_d_write();
        d_req = 1; d_we = 1;
        for (int i = 0; i < 3; i++) begin
            d_addr = 16'h0100 + 16'(i);
            d_wdata = 16'hC000 + 16'(i);
            #1;
            checks++;
            if ({d_gnt, m_gnt, mem_Write2, mem_Read2} !== 4'b1010 || mem_A2 !== d_addr) begin
                failures++; $display("FAIL dwr_drive[%0d] got=%b/%h exp=1010/%h", i, {d_gnt, m_gnt, mem_Write2, mem_Read2}, mem_A2, d_addr);
            end
            @(posedge clk); #1;
            checks++;
            if (d_rvalid !== 1'b0 || mem[10'h100 + 10'(i)] !== 16'hC000 + 16'(i)) begin
                failures++; $display("FAIL dwr_result[%0d] got=%b/%h exp=0/%h", i, d_rvalid, mem[10'h100 + 10'(i)], 16'hC000 + 16'(i));
            end
            @(negedge clk);
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_alternate();
        test_burst();
        test_read_before_write();
        test_reset_inflight();
        test_d_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
